// File: rtl/riscv_trace_buffer.sv
// Retired-instruction trace buffer: captures commits one-shot or circularly,
// stops on a PC-match trigger, then drains oldest-first through a valid/ready port.
module riscv_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       mode,
    input  logic                       commit_valid,
    input  logic [XLEN-1:0]            commit_pc,
    input  logic [XLEN-1:0]            commit_wb_data,
    input  logic [31:0]                commit_inst,
    input  logic                       commit_regwrite,
    input  logic                       trig_en,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [XLEN-1:0]            rd_pc,
    output logic [XLEN-1:0]            rd_wb_data,
    output logic [31:0]                rd_inst,
    output logic                       rd_regwrite,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 state,
    output logic                       overflow,
    output logic                       triggered
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_DONE    = 2'b10
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_mode;
    logic            r_overflow;
    logic            r_triggered;

    logic [XLEN-1:0] r_mem_pc   [DEPTH];
    logic [XLEN-1:0] r_mem_wb   [DEPTH];
    logic [31:0]     r_mem_inst [DEPTH];
    logic            r_mem_rw   [DEPTH];

    logic            w_wr_en;
    logic            w_trig_hit;
    logic            w_pop;
    logic [AW:0]     w_cnt_inc;

    // arm and reset both pre-empt the commit of their cycle
    assign w_wr_en    = (r_state == S_CAPTURE) && commit_valid && !arm && !rst;
    assign w_trig_hit = trig_en && (commit_pc == trig_pc);
    assign w_pop      = (r_state == S_DONE) && (r_count != '0) && rd_ready;
    assign w_cnt_inc  = r_count + 1'b1;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]   <= commit_pc;
            r_mem_wb[r_wr_ptr]   <= commit_wb_data;
            r_mem_inst[r_wr_ptr] <= commit_inst;
            r_mem_rw[r_wr_ptr]   <= commit_regwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_mode      <= 1'b0;
            r_overflow  <= 1'b0;
            r_triggered <= 1'b0;
        end else if (arm) begin
            r_state     <= S_CAPTURE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_mode      <= mode;
            r_overflow  <= 1'b0;
            r_triggered <= 1'b0;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    if (w_wr_en) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (!r_mode) begin
                            r_count <= w_cnt_inc;
                            if (w_cnt_inc == FULL)
                                r_state <= S_DONE;
                        end else if (r_count == FULL) begin
                            // circular and full: the oldest entry was just overwritten
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= w_cnt_inc;
                        end
                        if (w_trig_hit) begin
                            r_triggered <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (r_count == '0) begin
                        r_state <= S_IDLE;
                    end else if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_count  <= r_count - 1'b1;
                        if (r_count == 1)
                            r_state <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_valid    = (r_state == S_DONE) && (r_count != '0);
    assign rd_pc       = r_mem_pc[r_rd_ptr];
    assign rd_wb_data  = r_mem_wb[r_rd_ptr];
    assign rd_inst     = r_mem_inst[r_rd_ptr];
    assign rd_regwrite = r_mem_rw[r_rd_ptr];
    assign count       = r_count;
    assign state       = r_state;
    assign overflow    = r_overflow;
    assign triggered   = r_triggered;
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Scoreboard bench for riscv_trace_buffer at DEPTH=4: a small behavioural
// model queues expected entries per commit and drains are compared oldest-first.
module tb_riscv_trace_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              arm = 1'b0;
    logic              mode = 1'b0;
    logic              commit_valid = 1'b0;
    logic [XLEN-1:0]   commit_pc = '0;
    logic [XLEN-1:0]   commit_wb_data = '0;
    logic [31:0]       commit_inst = '0;
    logic              commit_regwrite = 1'b0;
    logic              trig_en = 1'b0;
    logic [XLEN-1:0]   trig_pc = '0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [XLEN-1:0]   rd_pc;
    logic [XLEN-1:0]   rd_wb_data;
    logic [31:0]       rd_inst;
    logic              rd_regwrite;
    logic [2:0]        count;
    logic [1:0]        state;
    logic              overflow;
    logic              triggered;

    riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .arm(arm), .mode(mode),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_wb_data(commit_wb_data), .commit_inst(commit_inst),
        .commit_regwrite(commit_regwrite), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_wb_data(rd_wb_data), .rd_inst(rd_inst), .rd_regwrite(rd_regwrite),
        .count(count), .state(state), .overflow(overflow), .triggered(triggered)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] wb;
        logic        rw;
    } ent_t;

    ent_t       m_q[$];
    logic [1:0] m_state = 2'b00;
    logic       m_mode = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_trg = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic do_reset();
        rst = 1'b1;
        m_q.delete(); m_state = 2'b00; m_ovf = 1'b0; m_trg = 1'b0; m_mode = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // arm_commit drives a commit in the arm cycle; it must not be recorded
    task automatic do_arm(input logic md, input logic arm_commit);
        arm = 1'b1; mode = md;
        commit_valid = arm_commit; commit_pc = 32'hDEAD_0000;
        m_q.delete(); m_state = 2'b01; m_mode = md; m_ovf = 1'b0; m_trg = 1'b0;
        @(posedge clk); #1;
        arm = 1'b0; commit_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] pc);
        ent_t e;
        e.pc = pc; e.inst = 32'h0000_0013 + (pc << 7); e.wb = ~pc ^ 32'h5A5A_0000; e.rw = pc[2];
        commit_valid = 1'b1; commit_pc = e.pc; commit_inst = e.inst;
        commit_wb_data = e.wb; commit_regwrite = e.rw;
        if (m_state == 2'b01) begin
            m_q.push_back(e);
            if (!m_mode && m_q.size() == DEPTH) m_state = 2'b10;
            if (m_mode && m_q.size() > DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
            end
            if (trig_en && pc == trig_pc) begin
                m_trg = 1'b1; m_state = 2'b10;
            end
        end
        @(posedge clk); #1;
        commit_valid = 1'b0;
    endtask

    task automatic do_pop(input logic rdy);
        rd_ready = rdy;
        if (m_state == 2'b10 && m_q.size() != 0 && rdy) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_state = 2'b00;
        end
        @(posedge clk); #1;
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (state !== 2'b00 || count !== 3'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || triggered !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: state=%b count=%0d rd_valid=%b ovf=%b trg=%b, want 00/0/0/0/0",
                     state, count, rd_valid, overflow, triggered);
        end
    endtask

    task automatic test_oneshot();
        trig_en = 1'b0;
        do_arm(1'b0, 1'b1);
        n_checks++;
        if (state !== 2'b01 || count !== 3'd0) begin
            n_errors++; $display("FAIL arm_oneshot: state=%b count=%0d, want 01/0", state, count);
        end
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_commit(32'(i * 4));
            n_checks++;
            if (state !== m_state || count !== 3'(m_q.size()) || rd_valid !== (m_state == 2'b10)) begin
                n_errors++;
                $display("FAIL oneshot_fill[%0d]: state=%b count=%0d rd_valid=%b, want %b/%0d", i, state, count, rd_valid, m_state, m_q.size());
            end
        end
        mode = 1'b0;
        for (int k = 0; k < 12 && m_q.size() != 0; k++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_pc !== m_q[0].pc || rd_inst !== m_q[0].inst ||
                rd_wb_data !== m_q[0].wb || rd_regwrite !== m_q[0].rw) begin
                n_errors++;
                $display("FAIL oneshot_drain: rd_valid=%b pc=%h inst=%h wb=%h rw=%b, want pc=%h inst=%h wb=%h rw=%b",
                         rd_valid, rd_pc, rd_inst, rd_wb_data, rd_regwrite, m_q[0].pc, m_q[0].inst, m_q[0].wb, m_q[0].rw);
            end
            do_pop(1'b1);
        end
        n_checks++;
        if (state !== 2'b00 || count !== 3'd0 || rd_valid !== 1'b0) begin
            n_errors++; $display("FAIL oneshot_idle: state=%b count=%0d rd_valid=%b, want 00/0/0", state, count, rd_valid);
        end
    endtask

    task automatic test_circular_trigger();
        trig_en = 1'b1; trig_pc = 32'h14;
        do_arm(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) do_commit(32'(i * 4));
        n_checks++;
        if (state !== 2'b10 || count !== 3'd4 || overflow !== 1'b1 || triggered !== 1'b1) begin
            n_errors++;
            $display("FAIL circ_flags: state=%b count=%0d ovf=%b trg=%b, want 10/4/1/1", state, count, overflow, triggered);
        end
        for (int k = 0; k < 12 && m_q.size() != 0; k++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_pc !== m_q[0].pc || rd_wb_data !== m_q[0].wb) begin
                n_errors++;
                $display("FAIL circ_drain: rd_valid=%b pc=%h wb=%h, want pc=%h wb=%h", rd_valid, rd_pc, rd_wb_data, m_q[0].pc, m_q[0].wb);
            end
            do_pop(1'b1);
        end
        n_checks++;
        if (state !== 2'b00 || overflow !== 1'b1 || triggered !== 1'b1) begin
            n_errors++; $display("FAIL circ_sticky: state=%b ovf=%b trg=%b, want 00/1/1", state, overflow, triggered);
        end
        trig_en = 1'b0;
    endtask

    task automatic test_trigger_oneshot();
        trig_en = 1'b1; trig_pc = 32'h08;
        do_arm(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_commit(32'(i * 4));
        n_checks++;
        if (state !== 2'b10 || count !== 3'd3 || triggered !== 1'b1 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL trig_stop: state=%b count=%0d trg=%b ovf=%b, want 10/3/1/0", state, count, triggered, overflow);
        end
        for (int k = 0; k < 12 && m_q.size() != 0; k++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_pc !== m_q[0].pc) begin
                n_errors++; $display("FAIL trig_drain: rd_valid=%b pc=%h, want pc=%h", rd_valid, rd_pc, m_q[0].pc);
            end
            do_pop(1'b1);
        end
        // trigger on the write that also fills the one-shot buffer
        trig_pc = 32'h4C;
        do_arm(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_commit(32'h40 + 32'(i * 4));
        n_checks++;
        if (state !== 2'b10 || count !== 3'd4 || triggered !== 1'b1 || rd_pc !== 32'h40) begin
            n_errors++;
            $display("FAIL trig_full: state=%b count=%0d trg=%b pc=%h, want 10/4/1/00000040", state, count, triggered, rd_pc);
        end
        trig_en = 1'b0;
    endtask

    task automatic test_ready_toggle();
        logic pat [7];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_arm(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_commit(32'h100 + 32'(i * 4));
        for (int k = 0; k < 7 && m_q.size() != 0; k++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_pc !== m_q[0].pc || count !== 3'(m_q.size())) begin
                n_errors++;
                $display("FAIL ready_toggle[%0d]: rd_valid=%b pc=%h count=%0d, want pc=%h count=%0d", k, rd_valid, rd_pc, count, m_q[0].pc, m_q.size());
            end
            do_pop(pat[k]);
        end
        n_checks++;
        if (state !== 2'b00 || rd_valid !== 1'b0) begin
            n_errors++; $display("FAIL ready_idle: state=%b rd_valid=%b, want 00/0", state, rd_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_arm(1'b0, 1'b0);
        do_commit(32'h200);
        do_commit(32'h204);
        n_checks++;
        if (count !== 3'd2 || state !== 2'b01) begin
            n_errors++; $display("FAIL mid_pre: count=%0d state=%b, want 2/01", count, state);
        end
        commit_valid = 1'b1; arm = 1'b1;
        do_reset();
        arm = 1'b0; commit_valid = 1'b0;
        n_checks++;
        if (state !== 2'b00 || count !== 3'd0 || rd_valid !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset: state=%b count=%0d rd_valid=%b, want 00/0/0", state, count, rd_valid);
        end
        do_arm(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_commit(32'h300 + 32'(i * 4));
        for (int k = 0; k < 12 && m_q.size() != 0; k++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_pc !== m_q[0].pc || rd_inst !== m_q[0].inst) begin
                n_errors++; $display("FAIL mid_rearm: rd_valid=%b pc=%h inst=%h, want pc=%h inst=%h", rd_valid, rd_pc, rd_inst, m_q[0].pc, m_q[0].inst);
            end
            do_pop(1'b1);
        end
    endtask

    task automatic test_arm_abort();
        trig_en = 1'b1; trig_pc = 32'h508;
        do_arm(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_commit(32'h500 + 32'(i * 4));
        n_checks++;
        if (state !== 2'b10 || count !== 3'd3 || triggered !== 1'b1) begin
            n_errors++; $display("FAIL abort_pre: state=%b count=%0d trg=%b, want 10/3/1", state, count, triggered);
        end
        trig_en = 1'b0;
        do_arm(1'b0, 1'b1);
        n_checks++;
        if (state !== 2'b01 || count !== 3'd0 || triggered !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_arm: state=%b count=%0d trg=%b ovf=%b rd_valid=%b, want 01/0/0/0/0", state, count, triggered, overflow, rd_valid);
        end
        for (int i = 0; i < 4; i++) do_commit(32'h600 + 32'(i * 4));
        n_checks++;
        if (state !== 2'b10 || rd_pc !== 32'h600 || count !== 3'd4) begin
            n_errors++; $display("FAIL abort_after: state=%b pc=%h count=%0d, want 10/00000600/4", state, rd_pc, count);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_circular_trigger();
        test_trigger_oneshot();
        test_reset();
        test_ready_toggle();
        test_reset_mid();
        test_arm_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/riscv_trace_buffer.md
RISCV_TRACE_BUFFER -- requirements
Module: riscv_trace_buffer

Interface
REQ-001 Parameter XLEN, default 32, data/PC width in bits.
REQ-002 Parameter DEPTH, default 16, entry count; power of two, 2 to 256.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 Port arm  input  1  pulse; clears buffer, starts capture.
REQ-006 Port mode  input  1  0 = one-shot (stop when full), 1 = circular (overwrite oldest); sampled on arm.
REQ-007 Port commit_valid  input  1  retired instruction this cycle.
REQ-008 Port commit_pc / commit_wb_data  input  XLEN each  PC and write-back data of retired instruction.
REQ-009 Port commit_inst  input  32  retired instruction word.
REQ-010 Port commit_regwrite  input  1  RegWrite of retired instruction.
REQ-011 Port trig_en  input  1  enables PC-match trigger.
REQ-012 Port trig_pc  input  XLEN  trigger PC.
REQ-013 Port rd_ready  input  1  drain consumer ready.
REQ-014 Port rd_valid  output  1  drain entry available.
REQ-015 Port rd_pc, rd_wb_data  output  XLEN each; rd_inst  output  32; rd_regwrite  output  1  oldest entry fields.
REQ-016 Port count  output  log2(DEPTH)+1  stored entries.
REQ-017 Port state  output  2  00 IDLE, 01 CAPTURE, 10 DONE.
REQ-018 Port overflow  output  1  sticky; circular capture overwrote an entry.
REQ-019 Port triggered  output  1  sticky; capture stopped by PC match.

Function
REQ-020 IDLE: commits ignored; arm -> CAPTURE next cycle, with wr_ptr=rd_ptr=count=0, overflow=triggered=0, mode latched.
REQ-021 CAPTURE: each cycle with commit_valid writes {pc,inst,wb_data,regwrite} at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-022 Mode 0: count increments per write; write bringing count to DEPTH -> DONE next cycle; no further writes.
REQ-023 Mode 1 with count==DEPTH: write overwrites oldest, rd_ptr increments modulo DEPTH, count holds DEPTH, overflow set.
REQ-024 Trigger: commit_valid && trig_en && commit_pc==trig_pc in CAPTURE -> matching entry written, triggered set, DONE next cycle.
REQ-025 Trigger and mode-0 full in same cycle -> single write, triggered=1, DONE.
REQ-026 DONE: rd_valid = (count!=0); rd_* combinationally reflect entry at rd_ptr (oldest first).
REQ-027 DONE pop: rd_valid && rd_ready -> rd_ptr+1 mod DEPTH, count-1; rd_* show next entry the following cycle.
REQ-028 DONE with count reaching 0 -> IDLE next cycle; overflow/triggered retained until next arm or reset.
REQ-029 rd_valid is 0 in IDLE and CAPTURE; rd_ready ignored there.
REQ-030 arm in CAPTURE or DONE aborts: contents discarded, REQ-020 initialisation, CAPTURE next cycle; commit in the arm cycle not recorded.
REQ-031 Mode changes outside an arm cycle have no effect.
REQ-032 Storage is inferable memory; no combinational path from commit_* to rd_*.

Reset
REQ-033 rst=1 at clock edge: state=IDLE, count=0, pointers=0, overflow=0, triggered=0, rd_valid=0; overrides arm and commits that cycle.
REQ-034 Memory contents need no reset; rd_pc/rd_inst/rd_wb_data/rd_regwrite undefined while rd_valid=0.
REQ-035 Reset mid-CAPTURE or mid-DONE discards all entries; next arm behaves as after power-up.

Verification
REQ-036 DEPTH=4, mode 0, arm, 6 commits PC 0x00,0x04..0x14 -> DONE after 4th, count=4, drain yields 0x00,0x04,0x08,0x0C, then IDLE.
REQ-037 DEPTH=4, mode 1, 6 commits PC 0x00..0x14, trig_pc=0x14 -> triggered=1, overflow=1, drain yields 0x08,0x0C,0x10,0x14.
REQ-038 mode 0, trig_pc=0x08, commits 0x00,0x04,0x08,0x0C -> DONE, count=3, 0x0C not stored.
REQ-039 DONE with rd_ready toggling 1,0,1 -> exactly one pop per ready-high cycle, rd_* stable while rd_ready=0.
REQ-040 rst asserted mid-capture (count=2) -> next cycle state=00, count=0, rd_valid=0; later arm records from empty.
REQ-041 arm during DONE with count=3 -> CAPTURE next cycle, count=0, flags cleared.
